// File: rtl/our_data_type_one_pkg.sv
`default_nettype none
// ============================================================================
// Module   : our_data_type_one_pkg
// Brief    : Constants and state encoding shared by the type ONE tx/rx blocks.
// Revision : 1.0 - initial release
// ============================================================================
package our_data_type_one_pkg;

  localparam int HDR_WORDS_DEF  = 31;
  localparam int DATA_WORDS_DEF = 200;
  localparam int HDR_BYTES      = 4 * HDR_WORDS_DEF;
  localparam int PKT_BYTES      = HDR_BYTES + 2 * DATA_WORDS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TRAILER = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/our_data_type_one_tx_byte_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : byte_out_reg
// Brief    : Valid/ready byte holding register; loads when empty or accepted.
// Revision : 1.0 - initial release
// ============================================================================
module byte_out_reg (
  input  logic       clock,
  input  logic       aclr,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       tx_ready,
  output logic       can_load,
  output logic [7:0] dataout,
  output logic       dout_valid
);

  assign can_load = ~dout_valid | tx_ready;

  // An accepted byte with nothing new to load leaves the register empty.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      dataout    <= 8'd0;
      dout_valid <= 1'b0;
    end else if (can_load) begin
      dout_valid <= load;
      if (load) dataout <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/our_data_type_one_tx.sv
`default_nettype none
// ============================================================================
// Module   : our_data_type_one_tx
// Brief    : Serializes a 992-bit header plus FIFO payload as a type ONE byte
//            stream. Optional trailer checksum: OUR_TYPE_ONE_TX_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module our_data_type_one_tx
  import our_data_type_one_pkg::*;
#(
  parameter int HDR_WORDS  = HDR_WORDS_DEF,
  parameter int DATA_WORDS = DATA_WORDS_DEF
) (
  input  logic                    clock,
  input  logic                    aclr,
  input  logic                    start,
  input  logic [32*HDR_WORDS-1:0] i_header,
  input  logic [15:0]             fifo_q,
  input  logic                    fifo_empty,
  output logic                    fifo_rdreq,
  output logic [7:0]              dataout,
  output logic                    dout_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int         c_HDR_BITS  = 32 * HDR_WORDS;
  localparam int         c_HDR_BYTES = 4 * HDR_WORDS;
  localparam int         c_PKT_BYTES = c_HDR_BYTES + 2 * DATA_WORDS;
  localparam logic [9:0] c_LAST_HDR  = 10'(c_HDR_BYTES - 1);
  localparam logic [9:0] c_LAST_PAY  = 10'(c_PKT_BYTES - 1);
`ifdef OUR_TYPE_ONE_TX_CHECKSUM_EN
  localparam logic [9:0] c_TRL_HI    = 10'(c_PKT_BYTES);
  localparam logic [9:0] c_TRL_LO    = 10'(c_PKT_BYTES + 1);
  logic [15:0]           r_csum;
`endif

  tx_state_t             r_state;
  logic [c_HDR_BITS-1:0] r_hdr;
  logic [9:0]            r_cnt;     // index of the next byte to load
  logic                  r_busy;
  logic                  r_done;

  logic                  w_can_load;
  logic                  w_load;
  logic                  w_pop;
  logic [7:0]            w_byte;

  // Header and payload word alignment keep the low byte on odd indices.
  always_comb begin
    w_load = 1'b0;
    w_pop  = 1'b0;
    w_byte = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (start && !r_busy && w_can_load) begin
          w_load = 1'b1;
          w_byte = i_header[c_HDR_BITS-1 -: 8];
        end
      end
      ST_HEADER: begin
        if (w_can_load) begin
          w_load = 1'b1;
          w_byte = r_hdr[c_HDR_BITS-1 -: 8];
        end
      end
      ST_PAYLOAD: begin
        if (w_can_load && !fifo_empty) begin
          w_load = 1'b1;
          w_pop  = r_cnt[0];
          w_byte = r_cnt[0] ? fifo_q[7:0] : fifo_q[15:8];
        end
      end
`ifdef OUR_TYPE_ONE_TX_CHECKSUM_EN
      ST_TRAILER: begin
        if (w_can_load) begin
          w_load = 1'b1;
          w_byte = (r_cnt == c_TRL_HI) ? r_csum[15:8] : r_csum[7:0];
        end
      end
`endif
      default: ;
    endcase
  end

  // Byte 0 goes straight from i_header so valid rises with busy.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_state <= ST_IDLE;
      r_hdr   <= '0;
      r_cnt   <= 10'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef OUR_TYPE_ONE_TX_CHECKSUM_EN
      r_csum  <= 16'd0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_load) r_cnt <= r_cnt + 10'd1;
      case (r_state)
        ST_IDLE: begin
          if (start && !r_busy) begin
            r_hdr   <= i_header << 8;
            r_cnt   <= 10'd1;
            r_busy  <= 1'b1;
            r_state <= ST_HEADER;
`ifdef OUR_TYPE_ONE_TX_CHECKSUM_EN
            r_csum  <= 16'd0;
`endif
          end else if (r_busy && dout_valid && tx_ready) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (w_load) begin
            r_hdr <= r_hdr << 8;
            if (r_cnt == c_LAST_HDR) r_state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_pop) begin
`ifdef OUR_TYPE_ONE_TX_CHECKSUM_EN
            r_csum <= r_csum + fifo_q;
            if (r_cnt == c_LAST_PAY) r_state <= ST_TRAILER;
`else
            if (r_cnt == c_LAST_PAY) r_state <= ST_IDLE;
`endif
          end
        end
`ifdef OUR_TYPE_ONE_TX_CHECKSUM_EN
        ST_TRAILER: begin
          if (w_load && r_cnt == c_TRL_LO) r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  byte_out_reg u_byte_out_reg (
    .clock      (clock),
    .aclr       (aclr),
    .load       (w_load),
    .din        (w_byte),
    .tx_ready   (tx_ready),
    .can_load   (w_can_load),
    .dataout    (dataout),
    .dout_valid (dout_valid)
  );

  assign fifo_rdreq = w_pop;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_our_data_type_one_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_our_data_type_one_tx
// Brief    : Self-checking bench: byte-stream model, FIFO model, directed tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_our_data_type_one_tx;

`ifdef OUR_TYPE_ONE_TX_CHECKSUM_EN
  localparam int NB = 526;
`else
  localparam int NB = 524;
`endif

  logic         clock = 1'b0;
  logic         aclr  = 1'b1;
  logic         start = 1'b0;
  logic [991:0] i_header = '0;
  logic [15:0]  fifo_q;
  logic         fifo_empty;
  logic         fifo_rdreq;
  logic [7:0]   dataout;
  logic         dout_valid;
  logic         tx_ready = 1'b1;
  logic         busy;
  logic         done;

  always #5 clock = ~clock;

  our_data_type_one_tx dut (
    .clock(clock), .aclr(aclr), .start(start), .i_header(i_header),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .dataout(dataout), .dout_valid(dout_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  // Show-ahead FIFO model: words below wr_ptr are visible.
  logic [15:0] fmem [0:255];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign fifo_empty = (rd_ptr >= wr_ptr);
  assign fifo_q     = fmem[rd_ptr[7:0]];

  initial forever begin
    @(posedge clock);
    if (fifo_rdreq && !aclr) rd_ptr <= rd_ptr + 1;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected byte stream and observation bookkeeping.
  logic [7:0] exp_q[$];
  logic [7:0] got [0:1023];
  int nbytes = 0, nrd = 0, ndone = 0, cyc = 0;
  int first_cyc = 0, last_len = 0;
  bit arm = 0, prev_hold = 0;
  logic [7:0] prev_byte = 8'd0;
  bit toggle_en = 0;

  initial forever begin
    @(posedge clock);
    #1;
    tx_ready = toggle_en ? ~tx_ready : 1'b1;
  end

  initial forever begin
    @(negedge clock);
    cyc++;
    if (aclr) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, dout_valid}, 32'd1);
        chk("hold_data", {24'd0, dataout}, {24'd0, prev_byte});
      end
      prev_hold = dout_valid && !tx_ready;
      prev_byte = dataout;
      if (arm && dout_valid) begin
        first_cyc = cyc;
        arm = 0;
      end
      if (dout_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", {24'd0, dataout}, 32'hFFFF_FFFF);
        else chk("stream_byte", {24'd0, dataout}, {24'd0, exp_q.pop_front()});
        got[nbytes[9:0]] = dataout;
        nbytes++;
      end
      if (fifo_rdreq) begin
        nrd++;
        if (fifo_empty) chk("rdreq_while_empty", 32'd1, 32'd0);
      end
      if (done) begin
        ndone++;
        last_len = cyc - first_cyc;
        chk("done_queue_left", exp_q.size(), 32'd0);
      end
    end
  end

  task automatic load_fifo(input int avail, input bit flat);
    for (int i = 0; i < 256; i++) fmem[i] = flat ? 16'h0101 : 16'(16'h0100 + i);
    rd_ptr = 0;
    wr_ptr = avail;
  endtask

  // Model: header bytes, payload hi/lo per word, optional sum trailer.
  task automatic build_expect();
    logic [15:0] sum;
    sum = 16'd0;
    exp_q.delete();
    for (int i = 0; i < 124; i++) exp_q.push_back(i_header[991 - 8*i -: 8]);
    for (int w = 0; w < 200; w++) begin
      exp_q.push_back(fmem[w][15:8]);
      exp_q.push_back(fmem[w][7:0]);
      sum = sum + fmem[w];
    end
`ifdef OUR_TYPE_ONE_TX_CHECKSUM_EN
    exp_q.push_back(sum[15:8]);
    exp_q.push_back(sum[7:0]);
`endif
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 4000 && ndone == d0; k++) @(posedge clock);
    chk("done_timeout", {31'd0, ndone != d0}, 32'd1);
    @(negedge clock);
  endtask

  task automatic wait_bytes(input int target);
    for (int k = 0; k < 4000 && nbytes < target; k++) @(negedge clock);
  endtask

  int b0, r0, d0;

  initial begin
    for (int i = 0; i < 124; i++) i_header[991 - 8*i -: 8] = 8'(i);
    load_fifo(200, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_dataout", {24'd0, dataout}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    aclr = 1'b0;

    // Test 1: full-rate packet with latency, length and literal bytes.
    build_expect();
    b0 = nbytes; r0 = nrd; d0 = ndone; arm = 1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    chk("lat_valid", {31'd0, dout_valid}, 32'd1);
    chk("lat_byte0", {24'd0, dataout}, 32'h00);
    wait_done(d0);
    chk("t1_bytes", nbytes - b0, NB);
    chk("t1_rdreq", nrd - r0, 200);
    chk("t1_len", last_len, NB);
    chk("t1_b123", {24'd0, got[10'(b0 + 123)]}, 32'h7B);
    chk("t1_b124", {24'd0, got[10'(b0 + 124)]}, 32'h01);
    chk("t1_b125", {24'd0, got[10'(b0 + 125)]}, 32'h00);
    chk("t1_b127", {24'd0, got[10'(b0 + 127)]}, 32'h01);
    chk("t1_b523", {24'd0, got[10'(b0 + 523)]}, 32'hC7);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_valid_after", {31'd0, dout_valid}, 32'd0);

    // Test 2: tx_ready toggling every cycle.
    load_fifo(200, 0);
    build_expect();
    toggle_en = 1;
    b0 = nbytes; r0 = nrd; d0 = ndone;
    pulse_start();
    wait_done(d0);
    toggle_en = 0;
    chk("t2_bytes", nbytes - b0, NB);
    chk("t2_rdreq", nrd - r0, 200);

    // Test 3: FIFO runs dry after 10 words, refilled 50 cycles later.
    repeat (2) @(posedge clock);
    load_fifo(10, 0);
    build_expect();
    b0 = nbytes; d0 = ndone;
    pulse_start();
    for (int k = 0; k < 2000 && rd_ptr < 10; k++) @(posedge clock);
    chk("t3_reach10", rd_ptr, 10);
    repeat (2) @(posedge clock);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      chk("t3_gap_valid", {31'd0, dout_valid}, 32'd0);
    end
    chk("t3_gap_rdptr", rd_ptr, 10);
    repeat (8) @(posedge clock);
    #1 wr_ptr = 200;
    wait_done(d0);
    chk("t3_bytes", nbytes - b0, NB);

    // Test 4: abort at byte 300, then a clean packet.
    repeat (2) @(posedge clock);
    load_fifo(200, 0);
    build_expect();
    b0 = nbytes;
    pulse_start();
    wait_bytes(b0 + 300);
    @(posedge clock); #1 aclr = 1'b1;
    #1;
    chk("abort_dataout", {24'd0, dataout}, 32'd0);
    chk("abort_valid", {31'd0, dout_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    @(posedge clock); #1 aclr = 1'b0;
    load_fifo(200, 0);
    build_expect();
    b0 = nbytes; r0 = nrd; d0 = ndone;
    pulse_start();
    wait_done(d0);
    chk("t4_bytes", nbytes - b0, NB);
    chk("t4_rdreq", nrd - r0, 200);

    // Test 5: start pulses mid-packet are ignored.
    load_fifo(200, 0);
    build_expect();
    b0 = nbytes; d0 = ndone;
    pulse_start();
    wait_bytes(b0 + 5);
    pulse_start();
    wait_bytes(b0 + 400);
    pulse_start();
    wait_done(d0);
    repeat (10) @(negedge clock);
    chk("t5_single_done", ndone - d0, 1);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    chk("t5_bytes", nbytes - b0, NB);

`ifdef OUR_TYPE_ONE_TX_CHECKSUM_EN
    // Test 6: flat payload gives a 0xC8C8 trailer.
    load_fifo(200, 1);
    build_expect();
    b0 = nbytes; d0 = ndone;
    pulse_start();
    wait_done(d0);
    chk("t6_bytes", nbytes - b0, 526);
    chk("t6_trl_hi", {24'd0, got[10'(b0 + 524)]}, 32'hC8);
    chk("t6_trl_lo", {24'd0, got[10'(b0 + 525)]}, 32'hC8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
